// File: rtl/qspi_target.sv
// Quad-SPI memory target: SPI/quad command, 6-nibble address, nibble write/read bursts; first read nibble READ_WAIT clocks after the address.
// No backpressure (the host owns the clock); QSPI_TARGET_WRAP_EN makes bursts wrap inside an aligned LINE_LENGTH window.
module qspi_target #(
   parameter int PA          = 24,
   parameter int READ_WAIT   = 7,
   parameter int LINE_LENGTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cs_n,
   input  logic [3:0]    sio_in,
   output logic [3:0]    sio_out,
   output logic [3:0]    sio_oe,
   output logic [PA-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [7:0]    mem_rdata
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      WDATA  = 3'd3,
      WAIT   = 3'd4,
      RDATA  = 3'd5,
      IGNORE = 3'd6
   } state_t;

   localparam logic [PA-1:0] ADDR_ONE = PA'(1);

   state_t        state_q;
   logic          quad_q;
   logic          powered_q;
   logic          is_read_q;
   logic          half_q;
   logic [3:0]    cnt_q;
   logic [7:0]    cmd_q;
   logic [19:0]   addr_sh_q;
   logic [3:0]    wnib_q;
   logic [7:0]    rbuf_q;
   logic [3:0]    sio_out_q;
   logic [3:0]    sio_oe_q;
   logic [PA-1:0] mem_addr_q;
   logic [7:0]    mem_wdata_q;
   logic          mem_we_q;
   logic          mem_re_q;

   logic [7:0]    cmd_d;
   logic          cmd_done_d;
   logic [23:0]   addr_d;
   logic [PA-1:0] addr_inc_d;
   logic [7:0]    rd_byte_d;

   assign cmd_d      = quad_q ? {cmd_q[3:0], sio_in} : {cmd_q[6:0], sio_in[0]};
   assign cmd_done_d = quad_q ? (cnt_q == 4'd1) : (cnt_q == 4'd7);
   assign addr_d     = {addr_sh_q, sio_in};

`ifdef QSPI_TARGET_WRAP_EN
   localparam logic [PA-1:0] WRAP_MASK = PA'(LINE_LENGTH - 1);
   assign addr_inc_d = (mem_addr_q & ~WRAP_MASK) | ((mem_addr_q + ADDR_ONE) & WRAP_MASK);
`else
   assign addr_inc_d = mem_addr_q + ADDR_ONE;
`endif

   // With the minimum wait the first byte goes straight from the bus to the pins.
   assign rd_byte_d = (READ_WAIT == 2) ? mem_rdata : rbuf_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         quad_q      <= 1'b0;
         powered_q   <= 1'b0;
         is_read_q   <= 1'b0;
         half_q      <= 1'b0;
         cnt_q       <= 4'd0;
         cmd_q       <= 8'h00;
         addr_sh_q   <= 20'h0;
         wnib_q      <= 4'h0;
         rbuf_q      <= 8'h00;
         sio_out_q   <= 4'h0;
         sio_oe_q    <= 4'h0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         mem_re_q <= 1'b0;
         if (cs_n) begin
            state_q  <= IDLE;
            sio_oe_q <= 4'h0;
         end else begin
            case (state_q)
               IDLE: begin
                  cmd_q   <= cmd_d;
                  cnt_q   <= 4'd1;
                  state_q <= CMD;
               end
               CMD: begin
                  cmd_q <= cmd_d;
                  cnt_q <= cnt_q + 4'd1;
                  if (cmd_done_d) begin
                     cnt_q   <= 4'd0;
                     state_q <= IGNORE;
                     if (cmd_d == 8'hAB) begin
                        powered_q <= 1'b1;
                     end else if (powered_q) begin
                        case (cmd_d)
                           8'h35: quad_q <= 1'b1;
                           8'hF5: quad_q <= 1'b0;
                           8'h38, 8'hEB: begin
                              is_read_q <= (cmd_d == 8'hEB);
                              state_q   <= ADDR;
                           end
                           default: ;
                        endcase
                     end
                  end
               end
               ADDR: begin
                  addr_sh_q <= addr_d[19:0];
                  cnt_q     <= cnt_q + 4'd1;
                  if (cnt_q == 4'd5) begin
                     mem_addr_q <= addr_d[PA-1:0];
                     cnt_q      <= 4'd1;
                     half_q     <= 1'b0;
                     state_q    <= is_read_q ? WAIT : WDATA;
                  end
               end
               WDATA: begin
                  half_q <= ~half_q;
                  if (!half_q) begin
                     wnib_q <= sio_in;
                     // Advance only after the previous byte's strobe has been seen.
                     if (mem_we_q) mem_addr_q <= addr_inc_d;
                  end else begin
                     mem_wdata_q <= {wnib_q, sio_in};
                     mem_we_q    <= 1'b1;
                  end
               end
               WAIT: begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd1) mem_re_q <= 1'b1;
                  if (cnt_q == 4'd2) rbuf_q <= mem_rdata;
                  if (cnt_q == 4'(READ_WAIT)) begin
                     sio_out_q <= rd_byte_d[7:4];
                     rbuf_q    <= rd_byte_d;
                     sio_oe_q  <= 4'hF;
                     half_q    <= 1'b1;
                     state_q   <= RDATA;
                  end
               end
               RDATA: begin
                  half_q <= ~half_q;
                  if (half_q) begin
                     // Fetch the next byte while the low nibble is on the pins.
                     sio_out_q  <= rbuf_q[3:0];
                     mem_addr_q <= addr_inc_d;
                     mem_re_q   <= 1'b1;
                  end else begin
                     sio_out_q <= mem_rdata[7:4];
                     rbuf_q    <= mem_rdata;
                  end
               end
               IGNORE: ;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign sio_out   = sio_out_q;
   assign sio_oe    = sio_oe_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_qspi_target.sv
// Scoreboarded bench for qspi_target: writes and read addresses are queued as stimulus is driven and popped on each strobe.
module tb_qspi_target;
   localparam int PA = 24;
   localparam int RW = 7;
   localparam int LL = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cs_n;
   logic [3:0]    sio_in;
   logic [3:0]    sio_out;
   logic [3:0]    sio_oe;
   logic [PA-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [7:0]    mem_rdata;

   typedef struct packed {
      logic [PA-1:0] a;
      logic [7:0]    d;
   } wr_t;

   logic [7:0]    mem [256];
   wr_t           exp_wr[$];
   logic [PA-1:0] exp_rd[$];
   logic [7:0]    obs_nib[$];
   logic          wait_oe;
   logic          end_oe;
   wr_t           mon_w;
   logic [PA-1:0] mon_a;
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   qspi_target #(.PA(PA), .READ_WAIT(RW), .LINE_LENGTH(LL)) dut (
      .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .sio_in(sio_in),
      .sio_out(sio_out), .sio_oe(sio_oe), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   // Read data is valid only in the cycle after the strobe.
   always @(negedge clk) mem_rdata = mem_re ? mem[mem_addr[7:0]] : 8'h00;

   always @(negedge clk) begin
      if (mem_we) begin
         checks++;
         if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL wr_unexpected got addr=%h data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            mon_w = exp_wr.pop_front();
            if (mem_addr !== mon_w.a || mem_wdata !== mon_w.d) begin
               failures++;
               $display("FAIL wr_strobe got addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_wdata, mon_w.a, mon_w.d);
            end
         end
      end
      if (mem_re) begin
         checks++;
         if (exp_rd.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected got addr=%h, required no read", mem_addr);
         end else begin
            mon_a = exp_rd.pop_front();
            if (mem_addr !== mon_a) begin
               failures++;
               $display("FAIL rd_strobe got addr=%h, required addr=%h", mem_addr, mon_a);
            end
         end
      end
   end

   task automatic step(input logic cs, input logic [3:0] d);
      cs_n = cs;
      sio_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic qm, input logic [7:0] c);
      if (qm) begin
         step(1'b0, c[7:4]);
         step(1'b0, c[3:0]);
      end else begin
         for (int i = 7; i >= 0; i--) step(1'b0, {3'b000, c[i]});
      end
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) step(1'b0, a[i*4 +: 4]);
   endtask

   task automatic read_frame(input logic qm, input logic [23:0] a, input int nnib);
      obs_nib.delete();
      wait_oe = 1'b0;
      send_cmd(qm, 8'hEB);
      send_addr(a);
      for (int i = 0; i < RW - 1; i++) begin
         step(1'b0, 4'h0);
         wait_oe = wait_oe | (|sio_oe);
      end
      for (int i = 0; i < nnib; i++) begin
         step(1'b0, 4'h0);
         obs_nib.push_back({sio_oe, sio_out});
      end
      step(1'b1, 4'h0);
      end_oe = |sio_oe;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) step(1'b1, 4'h0);
      checks++;
      if ({sio_oe, sio_out} !== 8'h00) begin
         failures++;
         $display("FAIL reset_sio got oe=%h out=%h, required oe=0 out=0", sio_oe, sio_out);
      end
      checks++;
      if ({mem_we, mem_re} !== 2'b00 || mem_addr !== '0) begin
         failures++;
         $display("FAIL reset_mem got we=%b re=%b addr=%h, required 0 0 0", mem_we, mem_re, mem_addr);
      end
      reset_n = 1'b1;
      step(1'b1, 4'h0);
   endtask

   task automatic test_power_up;
      send_cmd(1'b0, 8'h35);
      step(1'b1, 4'h0);
      send_cmd(1'b0, 8'hAB);
      step(1'b1, 4'h0);
      exp_rd.push_back(24'h000010);
      read_frame(1'b0, 24'h000010, 1);
      checks++;
      if (wait_oe !== 1'b0) begin
         failures++;
         $display("FAIL pwr_wait_oe got %b, required 0", wait_oe);
      end
      checks++;
      if (obs_nib.size() != 1 || obs_nib[0] !== 8'hFA) begin
         failures++;
         $display("FAIL pwr_spi_read got n=%0d first=%h, required n=1 first=fa", obs_nib.size(),
                  (obs_nib.size() > 0) ? obs_nib[0] : 8'h00);
      end
      checks++;
      if (exp_rd.size() != 0) begin
         failures++;
         $display("FAIL pwr_rd_queue got remaining=%0d, required 0", exp_rd.size());
      end
      send_cmd(1'b0, 8'h35);
      step(1'b1, 4'h0);
   endtask

   task automatic test_quad_write;
      exp_wr.push_back('{a: 24'h000102, d: 8'h12});
      exp_wr.push_back('{a: 24'h000103, d: 8'h34});
      send_cmd(1'b1, 8'h38);
      send_addr(24'h000102);
      step(1'b0, 4'h1);
      step(1'b0, 4'h2);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 24'h000102) begin
         failures++;
         $display("FAIL wr_first_strobe got we=%b addr=%h, required we=1 addr=000102", mem_we, mem_addr);
      end
      step(1'b0, 4'h3);
      step(1'b0, 4'h4);
      step(1'b1, 4'h0);
      step(1'b1, 4'h0);
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL wr_queue got remaining=%0d, required 0", exp_wr.size());
      end
   endtask

   task automatic test_quad_read;
      logic [3:0] en [4];
      en = '{4'hA, 4'h5, 4'h3, 4'hC};
      exp_rd.push_back(24'h000010);
      exp_rd.push_back(24'h000011);
      exp_rd.push_back(24'h000012);
      read_frame(1'b1, 24'h000010, 4);
      checks++;
      if (wait_oe !== 1'b0) begin
         failures++;
         $display("FAIL rd_wait_oe got %b, required 0", wait_oe);
      end
      checks++;
      if (obs_nib.size() != 4) begin
         failures++;
         $display("FAIL rd_count got %0d, required 4", obs_nib.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_nib[k] !== {4'hF, en[k]}) begin
               failures++;
               $display("FAIL rd_nibble%0d got oe/out=%h, required %h", k, obs_nib[k], {4'hF, en[k]});
            end
         end
      end
      checks++;
      if (end_oe !== 1'b0 || exp_rd.size() != 0) begin
         failures++;
         $display("FAIL rd_end got oe=%b remaining=%0d, required oe=0 remaining=0", end_oe, exp_rd.size());
      end
   endtask

   task automatic test_wrap;
      logic [PA-1:0] ea [6];
      logic [7:0]    b;
`ifdef QSPI_TARGET_WRAP_EN
      ea = '{24'h6, 24'h7, 24'h4, 24'h5, 24'h6, 24'h7};
`else
      ea = '{24'h6, 24'h7, 24'h8, 24'h9, 24'hA, 24'hB};
`endif
      for (int k = 0; k < 6; k++) exp_rd.push_back(ea[k]);
      read_frame(1'b1, 24'h000006, 10);
      checks++;
      if (obs_nib.size() != 10) begin
         failures++;
         $display("FAIL wrap_count got %0d, required 10", obs_nib.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            b = mem[ea[k][7:0]];
            checks++;
            if (obs_nib[2*k] !== {4'hF, b[7:4]} || obs_nib[2*k+1] !== {4'hF, b[3:0]}) begin
               failures++;
               $display("FAIL wrap_byte%0d got %h %h, required byte %h", k, obs_nib[2*k], obs_nib[2*k+1], b);
            end
         end
      end
      checks++;
      if (exp_rd.size() != 0) begin
         failures++;
         $display("FAIL wrap_rd_queue got remaining=%0d, required 0", exp_rd.size());
      end
   endtask

   task automatic test_abort;
      exp_wr.push_back('{a: 24'h000200, d: 8'h78});
      send_cmd(1'b1, 8'h38);
      send_addr(24'h000200);
      step(1'b0, 4'h7);
      step(1'b0, 4'h8);
      step(1'b0, 4'h9);
      step(1'b1, 4'h0);
      checks++;
      if (sio_oe !== 4'h0 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL abort_edge got oe=%h we=%b, required oe=0 we=0", sio_oe, mem_we);
      end
      step(1'b1, 4'h0);
      checks++;
      if (mem_we !== 1'b0 || exp_wr.size() != 0) begin
         failures++;
         $display("FAIL abort_writes got we=%b remaining=%0d, required we=0 remaining=0", mem_we, exp_wr.size());
      end
   endtask

   task automatic test_unknown;
      send_cmd(1'b1, 8'h5A);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 4'(i + 9));
         checks++;
         if (sio_oe !== 4'h0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            failures++;
            $display("FAIL unknown_quiet%0d got oe=%h we=%b re=%b, required 0 0 0", i, sio_oe, mem_we, mem_re);
         end
      end
      step(1'b1, 4'h0);
      exp_wr.push_back('{a: 24'h000300, d: 8'hBE});
      send_cmd(1'b1, 8'h38);
      send_addr(24'h000300);
      step(1'b0, 4'hB);
      step(1'b0, 4'hE);
      step(1'b1, 4'h0);
      step(1'b1, 4'h0);
      checks++;
      if (exp_wr.size() != 0) begin
         failures++;
         $display("FAIL unknown_next_frame got remaining=%0d, required 0", exp_wr.size());
      end
   endtask

   task automatic test_reset_midframe;
      send_cmd(1'b1, 8'h38);
      send_addr(24'h000400);
      step(1'b0, 4'h1);
      reset_n = 1'b0;
      step(1'b0, 4'h2);
      checks++;
      if (mem_we !== 1'b0 || sio_oe !== 4'h0 || mem_addr !== '0) begin
         failures++;
         $display("FAIL reset_mid got we=%b oe=%h addr=%h, required 0 0 0", mem_we, sio_oe, mem_addr);
      end
      reset_n = 1'b1;
      step(1'b1, 4'h0);
      send_cmd(1'b0, 8'h38);
      send_addr(24'h000500);
      step(1'b0, 4'h5);
      step(1'b0, 4'h6);
      checks++;
      if (mem_we !== 1'b0) begin
         failures++;
         $display("FAIL reset_unpowered got we=%b, required 0", mem_we);
      end
      step(1'b1, 4'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      cs_n = 1'b1;
      sio_in = 4'h0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 29 + 7);
      mem[8'h10] = 8'hA5;
      mem[8'h11] = 8'h3C;
      test_reset();
      test_power_up();
      test_quad_write();
      test_quad_read();
      test_wrap();
      test_abort();
      test_unknown();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/qspi_target.md
QSPI_TARGET -- requirements
Module: qspi_target

Interface
REQ-001 SHALL provide parameter PA, default 24, meaning the address width in bits; 6 address nibbles are always received, and the upper bits beyond PA are discarded.
REQ-002 SHALL provide parameter READ_WAIT, default 7, meaning the number of clocks from the last address-nibble sample to the first read-data nibble driven (legal range 2..15).
REQ-003 SHALL provide parameter LINE_LENGTH, default 4, meaning the wrap window in bytes (power of 2) used when the wrap feature is compiled in.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port cs_n, input, 1 bit: chip select, active low.
REQ-007 SHALL have port sio_in, input, 4 bits: sampled bus lines; bit 0 carries the SPI-mode serial input.
REQ-008 SHALL have port sio_out, output, 4 bits: registered drive value.
REQ-009 SHALL have port sio_oe, output, 4 bits: registered per-line output enable.
REQ-010 SHALL have port mem_addr, output, PA bits: backing-store byte address.
REQ-011 SHALL have port mem_wdata, output, 8 bits: write byte.
REQ-012 SHALL have port mem_we, output, 1 bit: one-cycle write strobe.
REQ-013 SHALL have port mem_re, output, 1 bit: one-cycle read strobe.
REQ-014 SHALL have port mem_rdata, input, 8 bits: read byte, valid exactly 1 clock after mem_re.

Function
REQ-015 SHALL sample cs_n and sio_in on every clk edge; a frame begins on the first edge with cs_n=0, and that edge carries the first command bit or nibble.
REQ-016 SHALL receive the command MSB-first as 8 bits on sio_in[0] when quad=0, or as 2 nibbles (high nibble first) when quad=1.
REQ-017 SHALL treat every command other than 0xAB as ignored while powered=0; powered resets to 0.
REQ-018 SHALL decode commands:
- 0xAB: powered=1.
- 0x35: quad=1.
- 0xF5: quad=0.
- 0x38: quad write.
- 0xEB: quad read.
- any other value: enter IGNORE until cs_n=1.
REQ-019 SHALL, for commands 0x38 and 0xEB, receive 6 address nibbles on sio_in[3:0], MSB nibble first, in either mode.
REQ-020 SHALL use the states IDLE, CMD, ADDR, WDATA, WAIT, RDATA and IGNORE, with transitions:
- CMD -> ADDR (0x38/0xEB) or IGNORE (otherwise).
- ADDR -> WDATA (0x38) or WAIT (0xEB).
- WAIT -> RDATA.
- any state -> IDLE on cs_n=1.
REQ-021 SHALL, in WDATA, assemble each pair of nibbles (high nibble first) into a byte, then pulse mem_we for 1 clock with mem_addr=current address, then increment the address.
REQ-022 SHALL, in the read path, pulse mem_re on the edge after the final address nibble, latch mem_rdata 1 clock later, and issue the next mem_re while the low nibble of the current byte is being driven.
REQ-023 SHALL drive sio_oe=4'hF and sio_out=byte[7:4] then byte[3:0] on successive clocks during RDATA, with the first nibble appearing READ_WAIT clocks after the last address sample.
REQ-024 SHALL hold sio_oe=0 in every state except RDATA.
REQ-025 SHALL, when cs_n=1 at any point, force the state to IDLE on that edge and clear sio_oe; a partial write byte is discarded and no mem_we is issued for it.
REQ-026 SHALL, without the wrap feature, increment the address linearly modulo 2^PA.
REQ-027 SHALL keep quad and powered unchanged across frames.

Reset
REQ-028 SHALL, while reset_n=0 at a clk edge, set: state=IDLE, quad=0, powered=0, sio_oe=0, sio_out=0, mem_we=0, mem_re=0, mem_addr=0.
REQ-029 SHALL let reset override an in-progress frame; no mem strobe is issued on the reset edge.

Configuration
REQ-030 SHALL, when QSPI_TARGET_WRAP_EN is defined, increment only address bits [log2(LINE_LENGTH)-1:0] and hold the upper bits, so bursts wrap within the aligned LINE_LENGTH window.
REQ-031 SHALL, when QSPI_TARGET_WRAP_EN is undefined, use linear increment as in REQ-026.

Verification
REQ-032 SHALL cover power-up and enter-quad: SPI 0xAB frame, then SPI 0x35 frame -> powered=1, quad=1; a prior 0x35 before 0xAB -> quad stays 0.
REQ-033 SHALL cover quad write: 0x38, address 0x000102, nibbles 1,2,3,4 -> mem_we twice: (0x000102,0x12), (0x000103,0x34).
REQ-034 SHALL cover quad read: memory 0x10=0xA5, 0x11=0x3C; 0xEB at address 0x000010 -> sio_out A,5,3,C starting exactly READ_WAIT clocks after the last address nibble, with sio_oe=F.
REQ-035 SHALL cover wrap: with QSPI_TARGET_WRAP_EN, read 5 bytes from 0x000006 -> addresses 6,7,4,5,6; without it -> 6,7,8,9,A.
REQ-036 SHALL cover abort: cs_n rises after 3 write nibbles -> exactly 1 mem_we, state IDLE, sio_oe=0 on the next clock.
REQ-037 SHALL cover unknown command: 0x5A -> no mem strobes, sio_oe=0 until cs_n=1, and the next frame decodes normally.
